data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 131 +++++++++++++
 tb/tb_data_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-channel data memory responder.
// Round-robin serialised access to a single-port word array.
module data_mem_responder #(
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 8,
   parameter int NUM_CHANNELS = 4,
   parameter int LATENCY      = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init_write_enable,
   input  logic [ADDR_BITS-1:0] init_address,
   input  logic [DATA_BITS-1:0] init_data,
   input  logic [NUM_CHANNELS-1:0] mem_read_valid,
   input  logic [ADDR_BITS-1:0] mem_read_address [NUM_CHANNELS],
   output logic [NUM_CHANNELS-1:0] mem_read_ready,
   output logic [DATA_BITS-1:0] mem_read_data [NUM_CHANNELS],
   input  logic [NUM_CHANNELS-1:0] mem_write_valid,
   input  logic [ADDR_BITS-1:0] mem_write_address [NUM_CHANNELS],
   input  logic [DATA_BITS-1:0] mem_write_data [NUM_CHANNELS],
   output logic [NUM_CHANNELS-1:0] mem_write_ready
);

   localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [3:0] CNT_INIT =
      (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, BUSY, ACK, DRAIN} state_t;

   state_t                 state_q [NUM_CHANNELS];
   state_t                 state_d [NUM_CHANNELS];
   logic [3:0]             cnt_q   [NUM_CHANNELS];
   logic [DATA_BITS-1:0]   rdata_q [NUM_CHANNELS];
   logic [DATA_BITS-1:0]   mem     [DEPTH];
   logic [NUM_CHANNELS-1:0] is_wr_q;
   logic [NUM_CHANNELS-1:0] req;
   logic [NUM_CHANNELS-1:0] gnt;
   logic [CW-1:0]          ptr_q;
   logic [CW-1:0]          gnt_idx;
   logic                   gnt_valid;
   logic                   gnt_wr;
   int                     cand;

   // Idle channels with a pending op request; preload and reset block all grants
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         req[i] = (state_q[i] == IDLE) &&
                  (mem_read_valid[i] || mem_write_valid[i]) &&
                  reset && !init_write_enable;
      end
   end

   // Round-robin search from the pointer upward, wrapping
   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         cand = (int'(ptr_q) + k) % NUM_CHANNELS;
         if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = CW'(cand);
         end
      end
      if (gnt_valid) gnt[gnt_idx] = 1'b1;
      gnt_wr = gnt_valid && mem_write_valid[gnt_idx];
   end

   // Per-channel next state; write wins when both valids are high
   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         state_d[i] = state_q[i];
         unique case (state_q[i])
            IDLE:  if (gnt[i]) state_d[i] = (LATENCY == 1) ? ACK : BUSY;
            BUSY:  if (cnt_q[i] == 4'd0) state_d[i] = ACK;
            ACK:   state_d[i] = DRAIN;
            DRAIN: if (is_wr_q[i] ? !mem_write_valid[i] : !mem_read_valid[i])
                      state_d[i] = IDLE;
            default: state_d[i] = IDLE;
         endcase
      end
   end

   // Ready pulses come from state only, so no input reaches an output
   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         mem_read_ready[i]  = (state_q[i] == ACK) && !is_wr_q[i];
         mem_write_ready[i] = (state_q[i] == ACK) && is_wr_q[i];
         mem_read_data[i]   = rdata_q[i];
      end
   end

   // Channel state, latency counters, read data and the arbiter pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= 4'd0;
            rdata_q[i] <= '0;
         end
         is_wr_q <= '0;
         ptr_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            if (gnt[i]) begin
               is_wr_q[i] <= mem_write_valid[i];
               cnt_q[i]   <= CNT_INIT;
               if (!mem_write_valid[i])
                  rdata_q[i] <= mem[mem_read_address[i]];
            end else if (state_q[i] == BUSY && cnt_q[i] != 4'd0) begin
               cnt_q[i] <= cnt_q[i] - 4'd1;
            end
         end
         if (gnt_valid)
            ptr_q <= (gnt_idx == CW'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Single write port: preload has priority, else the granted write
   always_ff @(posedge clk) begin
      if (init_write_enable)
         mem[init_address] <= init_data;
      else if (gnt_wr)
         mem[mem_write_address[gnt_idx]] <= mem_write_data[gnt_idx];
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder.
// Expected completions are queued at drive time and matched on ready.
module tb_data_mem_responder;

   localparam int L = 2;

   typedef struct {
      int         ch;
      bit         wr;
      int         cyc;
      logic [7:0] data;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       init_we;
   logic [7:0] init_addr;
   logic [7:0] init_data;
   logic [3:0] rv;
   logic [7:0] rd_addr [4];
   logic [3:0] rd_ready;
   logic [7:0] rd_data [4];
   logic [3:0] wv;
   logic [7:0] wr_addr [4];
   logic [7:0] wr_data [4];
   logic [3:0] wr_ready;

   exp_t q[$];
   int   cyc;
   int   total;
   int   passed;
   int   spurious;
   bit   auto_drop [4];

   data_mem_responder #(
      .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(L)
   ) dut (
      .clk(clk),
      .reset(reset),
      .init_write_enable(init_we),
      .init_address(init_addr),
      .init_data(init_data),
      .mem_read_valid(rv),
      .mem_read_address(rd_addr),
      .mem_read_ready(rd_ready),
      .mem_read_data(rd_data),
      .mem_write_valid(wv),
      .mem_write_address(wr_addr),
      .mem_write_data(wr_data),
      .mem_write_ready(wr_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic hit(input int c, input bit w);
      int idx = -1;
      for (int i = 0; i < q.size(); i++)
         if (idx < 0 && q[i].ch == c && q[i].wr == w) idx = i;
      if (idx < 0) begin
         spurious++;
         $display("unexpected ready ch%0d wr=%0d cycle %0d", c, w, cyc);
         return;
      end
      chk($sformatf("ch%0d_%s_cycle", c, w ? "wr" : "rd"), cyc, q[idx].cyc);
      if (!w) chk($sformatf("ch%0d_rd_data", c), rd_data[c], q[idx].data);
      q.delete(idx);
      if (auto_drop[c]) begin
         if (w) wv[c] = 1'b0;
         else   rv[c] = 1'b0;
      end
   endtask

   task automatic monitor();
      for (int c = 0; c < 4; c++) begin
         if (rd_ready[c]) hit(c, 1'b0);
         if (wr_ready[c]) hit(c, 1'b1);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic read_req(input int c, input logic [7:0] a,
                           input int lat, input logic [7:0] d);
      rv[c]      = 1'b1;
      rd_addr[c] = a;
      q.push_back('{ch: c, wr: 1'b0, cyc: cyc + lat, data: d});
   endtask

   task automatic write_req(input int c, input logic [7:0] a,
                            input logic [7:0] d, input int lat);
      wv[c]      = 1'b1;
      wr_addr[c] = a;
      wr_data[c] = d;
      q.push_back('{ch: c, wr: 1'b1, cyc: cyc + lat, data: 8'h00});
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      init_we   = 1'b1;
      init_addr = a;
      init_data = d;
      tick();
      init_we = 1'b0;
   endtask

   task automatic settle(input string tag, input int budget);
      int b = 0;
      while (q.size() > 0 && b < budget) begin
         tick();
         b++;
      end
      chk({tag, "_all_done"}, q.size(), 0);
      repeat (3) tick();
      chk({tag, "_no_extra"}, spurious, 0);
   endtask

   initial begin
      total = 0; passed = 0; spurious = 0; cyc = 0;
      init_we = 0; init_addr = 0; init_data = 0;
      rv = 0; wv = 0;
      for (int c = 0; c < 4; c++) begin
         rd_addr[c] = 0; wr_addr[c] = 0; wr_data[c] = 0;
         auto_drop[c] = 1'b1;
      end
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      chk("rst_rd_ready", rd_ready, 4'h0);
      chk("rst_wr_ready", wr_ready, 4'h0);
      for (int c = 0; c < 4; c++)
         chk($sformatf("rst_rd_data%0d", c), rd_data[c], 8'h00);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      preload(8'h10, 8'hAB);
      preload(8'h11, 8'hCD);
      preload(8'h12, 8'hEF);
      preload(8'h13, 8'h12);
      preload(8'h30, 8'h11);

      // single read, then data holds
      read_req(0, 8'h10, L, 8'hAB);
      tick();
      settle("single", 20);
      repeat (3) tick();
      chk("single_hold", rd_data[0], 8'hAB);

      // preload in the request cycle stalls the grant one cycle
      read_req(3, 8'h11, L + 1, 8'hCD);
      init_we = 1'b1; init_addr = 8'h50; init_data = 8'h3C;
      tick();
      init_we = 1'b0;
      settle("preload_stall", 20);

      // four-way contention from pointer 0
      for (int c = 0; c < 4; c++) begin
         logic [7:0] a;
         logic [7:0] d;
         a = 8'h10 + 8'(c);
         d = (c == 0) ? 8'hAB : (c == 1) ? 8'hCD : (c == 2) ? 8'hEF : 8'h12;
         read_req(c, a, L + c, d);
      end
      tick();
      settle("contend4", 30);

      // pointer back at 0: ch0 beats ch3
      read_req(3, 8'h50, L + 1, 8'h3C);
      read_req(0, 8'h12, L, 8'hEF);
      tick();
      settle("ptr0", 20);

      // write ch1 and read ch2 of the same address
      write_req(1, 8'h20, 8'h55, L);
      read_req(2, 8'h20, L + 1, 8'h55);
      tick();
      settle("wr_rd", 20);

      // read and write together on ch0: write first, then read
      write_req(0, 8'h30, 8'h77, L);
      read_req(0, 8'h30, L + 4, 8'h77);
      tick();
      settle("rdwr_same_ch", 30);

      // slow consumer on ch3
      auto_drop[3] = 1'b0;
      read_req(3, 8'h11, L, 8'hCD);
      repeat (L + 5) tick();
      chk("slow_done", q.size(), 0);
      chk("slow_one_pulse", spurious, 0);
      chk("slow_ready_low", rd_ready[3], 1'b0);
      rv[3] = 1'b0;
      auto_drop[3] = 1'b1;
      tick();
      read_req(3, 8'h20, L, 8'h55);
      tick();
      settle("slow_rerun", 20);

      // reset while ch0 is busy on a write
      wv[0] = 1'b1; wr_addr[0] = 8'h40; wr_data[0] = 8'h99;
      tick();
      #2 reset = 1'b0;
      #1;
      chk("midrst_rd_ready", rd_ready, 4'h0);
      chk("midrst_wr_ready", wr_ready, 4'h0);
      for (int c = 0; c < 4; c++)
         chk($sformatf("midrst_rd_data%0d", c), rd_data[c], 8'h00);
      wv[0] = 1'b0;
      tick();
      reset = 1'b1;
      repeat (6) tick();
      chk("midrst_no_pulse", spurious, 0);
      read_req(1, 8'h40, L, 8'h99);
      tick();
      settle("midrst_persist", 20);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
